// File: rtl/bch_pkg.sv
// Shared constants for the BCH test path and the error injector FSM encoding.
//   BCH_N  - codeword length (bits)
//   BCH_K  - message length (bits)
//   BCH_LW - width of a bit-position index into a codeword
package bch_pkg;

    localparam int BCH_N  = 63;
    localparam int BCH_K  = 56;
    localparam int BCH_LW = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INJECT = 2'd1,
        OUT    = 2'd2
    } state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Ports:
//   clk   - clock
//   rst_n - async active-low reset, loads SEED
//   state - current LFSR contents
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    // Right-shifting Galois form: the bit shifted out of bit 0 is fed back
    // into the tap positions of the polynomial.
    localparam logic [15:0] TAPS = 16'hB400;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/err_inject.sv
// Error injector: accepts a clean codeword, flips up to MAX_E bits at either
// configured or pseudo-random positions, and presents the corrupted word
// together with the applied error mask.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   in_valid/in_ready   - input handshake; in_data is the clean codeword
//   cfg_ne              - requested error count (clamped to MAX_E)
//   cfg_pos             - fixed positions, slot k at [k*LW +: LW]
//   cfg_rand            - 1 = random distinct positions, 0 = cfg_pos
//   out_valid/out_ready - output handshake
//   out_data, out_mask  - corrupted word and the pattern that was applied
//   out_err             - a fixed-mode position was outside the codeword
//
// state  | meaning
// IDLE   | ready for a word, latches data and config on in_valid
// INJECT | one slot (fixed) or one candidate (random) per cycle
// OUT    | result held until out_ready
module err_inject
    import bch_pkg::*;
#(
    parameter int          N     = BCH_N,
    parameter int          LW    = BCH_LW,
    parameter int          MAX_E = 3,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_data,
    input  logic [2:0]          cfg_ne,
    input  logic [MAX_E*LW-1:0] cfg_pos,
    input  logic                cfg_rand,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_data,
    output logic [N-1:0]        out_mask,
    output logic                out_err
);

    localparam logic [2:0]  MAX_E_C = 3'(MAX_E);
    localparam logic [LW:0] N_C     = (LW+1)'(N);

    state_t              state, state_n;
    logic [N-1:0]        data_r, data_n;
    logic [N-1:0]        mask_r, mask_n;
    logic [MAX_E*LW-1:0] pos_r, pos_n;
    logic                rand_r, rand_n;
    logic [2:0]          ne_r, ne_n;
    logic [2:0]          k_r, k_n;
    logic                err_r, err_n;

    logic [15:0]         lfsr_state;
    logic [LW-1:0]       cand;
    logic [LW-1:0]       pos_k;
    logic                last_slot;
    logic                unused_lfsr;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr_state)
    );

    assign cand        = lfsr_state[LW-1:0];
    assign unused_lfsr = ^lfsr_state[15:LW];
    assign last_slot   = (k_r == ne_r - 3'd1);

    always_comb begin
        pos_k = '0;
        for (int s = 0; s < MAX_E; s++) begin
            if (k_r == 3'(s)) begin
                pos_k = pos_r[s*LW +: LW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            data_r <= '0;
            mask_r <= '0;
            pos_r  <= '0;
            rand_r <= 1'b0;
            ne_r   <= '0;
            k_r    <= '0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_n;
            data_r <= data_n;
            mask_r <= mask_n;
            pos_r  <= pos_n;
            rand_r <= rand_n;
            ne_r   <= ne_n;
            k_r    <= k_n;
            err_r  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        data_n  = data_r;
        mask_n  = mask_r;
        pos_n   = pos_r;
        rand_n  = rand_r;
        ne_n    = ne_r;
        k_n     = k_r;
        err_n   = err_r;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    data_n  = in_data;
                    pos_n   = cfg_pos;
                    rand_n  = cfg_rand;
                    ne_n    = (cfg_ne > MAX_E_C) ? MAX_E_C : cfg_ne;
                    mask_n  = '0;
                    k_n     = '0;
                    err_n   = 1'b0;
                    state_n = (ne_n == 3'd0) ? OUT : INJECT;
                end
            end
            INJECT: begin
                if (!rand_r) begin
                    // Setting (not toggling) makes duplicate slots flip once.
                    if ({1'b0, pos_k} < N_C) begin
                        mask_n[pos_k] = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                    k_n = k_r + 3'd1;
                    if (last_slot) begin
                        state_n = OUT;
                    end
                end else if (({1'b0, cand} < N_C) && !mask_r[cand]) begin
                    // Rejecting out-of-range and already-set candidates
                    // guarantees exactly ne_r distinct flips.
                    mask_n[cand] = 1'b1;
                    k_n          = k_r + 3'd1;
                    if (last_slot) begin
                        state_n = OUT;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign out_data  = data_r ^ mask_r;
    assign out_mask  = mask_r;
    assign out_err   = err_r;

endmodule

// File: tb/tb_err_inject.sv
module tb_err_inject;

    localparam int N  = 63;
    localparam int LW = 6;
    localparam int ME = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [2:0]    cfg_ne;
    logic [ME*LW-1:0] cfg_pos;
    logic          cfg_rand;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [N-1:0]  out_mask;
    logic          out_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    err_inject #(.N(N), .LW(LW), .MAX_E(ME), .SEED(16'hACE1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_ne    (cfg_ne),
        .cfg_pos   (cfg_pos),
        .cfg_rand  (cfg_rand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_err   (out_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [N-1:0] rand_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[N-1:0];
    endfunction

    // Offer one word right after an edge (launch edge T); it is sampled at
    // T+1. Fixed mode must show out_valid after edge T+1+ne_eff. The output
    // is then held for 'hold' cycles with out_ready=0 before being taken.
    task automatic run_word(input logic [N-1:0] d, input logic [2:0] ne,
                            input logic [ME*LW-1:0] pos, input logic rnd,
                            input int hold);
        int            ne_eff;
        int            cycles;
        logic [N-1:0]  em;
        logic          ee;
        logic [LW-1:0] p;
        logic [N-1:0]  sd, sm;
        logic          stable;

        ne_eff = (ne > 3'(ME)) ? ME : int'(ne);
        chk("ready_before", in_ready, 1);
        in_valid = 1'b1; in_data = d; cfg_ne = ne; cfg_pos = pos; cfg_rand = rnd;
        @(posedge clk); #1;
        // Scramble inputs: the word in flight must not see these.
        in_valid = 1'b0; in_data = rand_word(); cfg_ne = 3'($urandom);
        cfg_pos = 18'($urandom); cfg_rand = ~rnd;

        cycles = 0;
        while (!out_valid && cycles < 3000) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
            return;
        end

        if (!rnd) begin
            em = '0; ee = 1'b0;
            for (int s = 0; s < ne_eff; s++) begin
                p = pos[s*LW +: LW];
                if (int'(p) < N) em[p] = 1'b1;
                else ee = 1'b1;
            end
            chk("fix_latency", 64'(cycles), 64'(ne_eff));
            chk("fix_mask", out_mask, em);
            chk("fix_data", out_data, d ^ em);
            chk("fix_err", out_err, ee);
        end else begin
            chk("rnd_popcount", 64'($countones(out_mask)), 64'(ne_eff));
            chk("rnd_data", out_data ^ d, out_mask);
            chk("rnd_err", out_err, 0);
        end

        if (hold > 0) begin
            sd = out_data; sm = out_mask; stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (out_data !== sd || out_mask !== sm || out_valid !== 1'b1 || in_ready !== 1'b0)
                    stable = 1'b0;
            end
            chk("hold_stable", stable, 1);
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("accept_resume", in_ready, 1);
        chk("valid_dropped", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_ne = '0;
        cfg_pos = '0; cfg_rand = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_out_err", out_err, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_word('0, 3'd3, {6'd0, 6'd1, 6'd2}, 1'b0, 0);
        run_word(63'h5A5A, 3'd0, 18'h3FFFF, 1'b0, 0);
        run_word(rand_word(), 3'd3, {6'd62, 6'd63, 6'd62}, 1'b0, 0);
        run_word(rand_word(), 3'd7, {6'd5, 6'd5, 6'd40}, 1'b0, 0);
        run_word(rand_word(), 3'd2, {6'd9, 6'd30, 6'd61}, 1'b0, 5);

        // Reset in the middle of INJECT.
        in_valid = 1'b1; in_data = rand_word(); cfg_ne = 3'd3;
        cfg_pos = {6'd3, 6'd4, 6'd5}; cfg_rand = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("inj_busy", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_mask", out_mask, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_word(63'h1234, 3'd1, {6'd0, 6'd0, 6'd7}, 1'b0, 0);

        // Randomized fixed-mode words, occasional out-of-range slots.
        for (int w = 0; w < 300; w++) begin
            logic [ME*LW-1:0] pv;
            for (int s = 0; s < ME; s++)
                pv[s*LW +: LW] = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 62));
            run_word(rand_word(), 3'($urandom_range(0, 7)), pv, 1'b0, $urandom_range(0, 2));
        end

        // Random mode, clamped count.
        for (int w = 0; w < 1000; w++) begin
            run_word(rand_word(), 3'd7, 18'($urandom), 1'b1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/err_inject.md
ERR_INJECT -- requirements
Module: err_inject

Interface
REQ-001 Parameters SHALL be:
- N, 63, codeword width.
- LW, 6, bit-position width; 2^LW SHALL be at least N.
- MAX_E, 3, maximum errors per word; legal range 1..7.
- SEED, 16'hACE1, LFSR reset value; SHALL be nonzero.
REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  clock.
- rst_n  in  1  reset.
- in_valid  in  1  input word offered.
- in_ready  out  1  block can accept a word.
- in_data  in  N  clean codeword.
- cfg_ne  in  3  requested error count.
- cfg_pos  in  MAX_E*LW  error positions; slot k is bits [k*LW +: LW].
- cfg_rand  in  1  1 = random positions, 0 = cfg_pos positions.
- out_valid  out  1  corrupted word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  N  corrupted codeword.
- out_mask  out  N  applied error pattern.
- out_err  out  1  at least one position was out of range (fixed mode).
REQ-003 Reset SHALL be rst_n, asynchronous, active-low; the clock SHALL be clk; all flops SHALL be rising-edge.

Function
REQ-004 FSM states SHALL be IDLE, INJECT and OUT; reset state IDLE.
REQ-005 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is OUT.
REQ-006 IDLE, in_valid=1: latch in_data, cfg_pos and cfg_rand; set ne_r = min(cfg_ne, MAX_E); clear mask, k and out_err.
- Next state SHALL be OUT if ne_r=0, else INJECT.
REQ-007 INJECT, fixed mode: each cycle SHALL process slot k.
- If pos[k] < N, set mask[pos[k]] = 1.
- If pos[k] >= N, set out_err and leave mask unchanged.
- Increment k; leave for OUT after the cycle in which k = ne_r-1.
REQ-008 INJECT, random mode: candidate = LFSR[LW-1:0].
- Candidate < N and mask[candidate] = 0: set the bit and increment k.
- Otherwise: retry next cycle with k unchanged.
- Random mode SHALL therefore always yield exactly ne_r distinct flipped bits.
REQ-009 Fixed-mode duplicate positions SHALL OR into mask, flipping once, not toggling twice.
REQ-010 In OUT, out_data SHALL equal data_r XOR mask and out_mask SHALL equal mask.
- Both SHALL stay stable while out_valid=1 and out_ready=0.
REQ-011 OUT, out_ready=1: handshake completes; next state IDLE.
- A new word SHALL be accepted no earlier than the cycle after that handshake.
REQ-012 Fixed-mode latency: word accepted at edge T SHALL give out_valid=1 after edge T+1+ne_r; ne_r=0 gives T+1.
REQ-013 in_data and cfg_* changes after the accept edge SHALL not affect the word in flight.
REQ-014 LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
- SHALL advance every clock cycle regardless of state.
REQ-015 cfg_ne above MAX_E SHALL clamp to MAX_E; this SHALL not set out_err.

Reset
REQ-016 While rst_n=0:
- state=IDLE, hence in_ready=1 and out_valid=0.
- out_data, out_mask, data_r, mask, k and ne_r = 0; out_err = 0.
- LFSR = SEED.
REQ-017 Reset asserted mid-INJECT or mid-OUT SHALL discard the word; no partial output SHALL appear after release.

Structure
REQ-018 Package bch_pkg SHALL hold BCH_N=63, BCH_K=56, BCH_LW=6 and the FSM state enum; parameter defaults SHALL come from it.
REQ-019 The LFSR SHALL be a sub-module lfsr16 with clk, rst_n, SEED parameter and 16-bit state output.

Verification
REQ-020 Fixed mode, in_data=0, cfg_ne=3, pos={2,1,0}, out_ready=1:
- out_data=63'h7 and out_mask=63'h7 after edge T+4; out_err=0.
REQ-021 cfg_ne=0, in_data=63'h5A5A:
- out_data=63'h5A5A and mask=0 after edge T+1.
REQ-022 Fixed mode, pos={62,63,62}, cfg_ne=3:
- mask has only bit 62 set; out_err=1.
REQ-023 Random mode, cfg_ne=7 clamps to 3, run 1000 words:
- popcount(out_mask)=3 every word; all set bits below 63; out_data^in_data=out_mask.
REQ-024 Hold out_ready=0 for 5 cycles in OUT:
- out_data stable and in_ready=0 throughout; accept resumes the cycle after out_ready=1.
REQ-025 Assert rst_n=0 during INJECT:
- out_valid=0 and in_ready=1 immediately; the next word is processed cleanly.
